// File: rtl/immgen.sv
// RV32I immediate generator: opcode-driven format decode with a combinational
// immediate for the single-cycle path and a registered copy for later consumers.
module immgen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic [31:0] imm_out,
  output logic [2:0]  imm_type,
  output logic [31:0] imm_q,
  output logic [2:0]  imm_type_q
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_SB   = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_UJ   = 3'd5;

  logic [6:0] opcode_s;
  assign opcode_s = inst[6:0];

  // Format decode and immediate assembly; funct3/funct7 never participate.
  always_comb begin
    imm_out  = 32'd0;
    imm_type = T_NONE;
    case (opcode_s)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        imm_out  = {{20{inst[31]}}, inst[31:20]};
        imm_type = T_I;
      end
      OP_STORE: begin
        imm_out  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_type = T_S;
      end
      OP_BRANCH: begin
        imm_out  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_type = T_SB;
      end
      OP_LUI, OP_AUIPC: begin
        imm_out  = {inst[31:12], 12'd0};
        imm_type = T_U;
      end
      OP_JAL: begin
        imm_out  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_type = T_UJ;
      end
      default: begin
        imm_out  = 32'd0;
        imm_type = T_NONE;
      end
    endcase
  end

  // Registered copy, loaded every cycle; reset clears only this copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q      <= 32'd0;
      imm_type_q <= 3'd0;
    end else begin
      imm_q      <= imm_out;
      imm_type_q <= imm_type;
    end
  end

endmodule

// File: tb/tb_immgen.sv
// Directed self-checking bench for immgen: every format, sign handling,
// registered latency and asynchronous reset behaviour.
module tb_immgen;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] imm_out;
  logic [2:0]  imm_type;
  logic [31:0] imm_q;
  logic [2:0]  imm_type_q;

  int checks = 0;
  int errors = 0;

  immgen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .imm_out    (imm_out),
    .imm_type   (imm_type),
    .imm_q      (imm_q),
    .imm_type_q (imm_type_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [12:0] nb;
    logic [20:0] nj;
    logic [31:0] inst_i, inst_uj, inst_s;

    rst_n = 1'b0;
    inst  = 32'd0;
    #1;
    chk("reset_imm_q", imm_q, 32'd0);
    chk("reset_type_q", {29'd0, imm_type_q}, 32'd0);
    chk("zero_inst_imm", imm_out, 32'd0);

    #3 rst_n = 1'b1;

    // R-type: no immediate
    inst = {25'd1238, 7'b0110011}; #1;
    chk("r_imm", imm_out, 32'd0);
    chk("r_type", {29'd0, imm_type}, 32'd0);

    // I-type all ones -> -1
    inst = {12'hFFF, 13'b0, 7'b0010011}; #1;
    chk("i_neg_imm", imm_out, 32'hFFFFFFFF);
    chk("i_neg_type", {29'd0, imm_type}, 32'd1);

    // I load, positive
    inst_i = {12'd1241, 13'b0, 7'b0000011};
    inst = inst_i; #1;
    chk("i_load_imm", imm_out, 32'd1241);
    chk("i_load_type", {29'd0, imm_type}, 32'd1);

    // JALR and SYSTEM with nonzero funct3 / rs fields
    inst = {12'h800, 5'd3, 3'b111, 5'd9, 7'b1100111}; #1;
    chk("jalr_imm", imm_out, 32'hFFFFF800);
    inst = {12'h7FF, 5'd0, 3'b001, 5'd0, 7'b1110011}; #1;
    chk("system_imm", imm_out, 32'h000007FF);
    chk("system_type", {29'd0, imm_type}, 32'd1);

    // S-type 1241 = {38, 25}
    inst_s = {7'd38, 13'b0, 5'd25, 7'b0100011};
    inst = inst_s; #1;
    chk("s_imm", imm_out, 32'd1241);
    chk("s_type", {29'd0, imm_type}, 32'd2);

    // SB positive and negative offsets
    nb = 13'd2358;
    inst = {nb[12], nb[10:5], 13'b0, nb[4:1], nb[11], 7'b1100011}; #1;
    chk("sb_pos_imm", imm_out, 32'd2358);
    chk("sb_type", {29'd0, imm_type}, 32'd3);
    nb[12] = 1'b1;
    inst = {nb[12], nb[10:5], 13'b0, nb[4:1], nb[11], 7'b1100011}; #1;
    chk("sb_neg_imm", imm_out, 32'hFFFFF936);

    // U-type LUI and AUIPC
    inst = {20'h014DA, 5'b0, 7'b0110111}; #1;
    chk("lui_imm", imm_out, 32'h014DA000);
    chk("lui_type", {29'd0, imm_type}, 32'd4);
    inst = {20'hFEDCB, 5'd7, 7'b0010111}; #1;
    chk("auipc_imm", imm_out, 32'hFEDCB000);

    // UJ positive and negative
    nj = 21'd831444;
    inst_uj = {nj[20], nj[10:1], nj[11], nj[19:12], 5'b0, 7'b1101111};
    inst = inst_uj; #1;
    chk("uj_imm", imm_out, 32'd831444);
    chk("uj_type", {29'd0, imm_type}, 32'd5);
    inst = {1'b1, 10'd0, 1'b0, 8'd0, 5'b0, 7'b1101111}; #1;
    chk("uj_neg_imm", imm_out, 32'hFFF00000);

    // Unlisted opcode with all other bits set
    inst = 32'hFFFFFF7F; #1;
    chk("unlisted_imm", imm_out, 32'd0);
    chk("unlisted_type", {29'd0, imm_type}, 32'd0);

    // Registered path: one-cycle latency
    @(negedge clk);
    inst = inst_i;
    @(posedge clk); #1;
    chk("reg_i_imm_q", imm_q, 32'd1241);
    chk("reg_i_type_q", {29'd0, imm_type_q}, 32'd1);
    inst = inst_uj; #1;
    chk("reg_hold_imm_q", imm_q, 32'd1241);
    chk("reg_hold_imm_out", imm_out, 32'd831444);

    // Asynchronous reset between edges
    #1 rst_n = 1'b0; #1;
    chk("async_rst_imm_q", imm_q, 32'd0);
    chk("async_rst_type_q", {29'd0, imm_type_q}, 32'd0);
    chk("async_rst_imm_out", imm_out, 32'd831444);
    inst = inst_s;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_imm_q", imm_q, 32'd0);
    chk("rst_track_imm_out", imm_out, 32'd1241);

    // Release and reload
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_imm_q", imm_q, 32'd1241);
    chk("release_type_q", {29'd0, imm_type_q}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
